// File: rtl/pkt_rr_arbiter.sv
// Round-robin packet arbiter: shares one framed valid/head/tail/data channel
// among NUM_REQ requesters. Ownership changes only at packet boundaries, and
// the block reports per-packet beat counts and framing violations.
module pkt_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_head,
    input  logic [NUM_REQ-1:0]        req_tail,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic                      out_head,
    output logic                      out_tail,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      pkt_done,
    output logic [LEN_W-1:0]          pkt_len,
    output logic                      err
);

    localparam int unsigned N     = NUM_REQ;
    localparam int          IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOCK = 2'd1;
    localparam logic [1:0] BODY = 2'd2;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [1:0]         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   next_ptr;
    logic               found;
    logic [NUM_REQ-1:0] grant_q;
    logic [LEN_W-1:0]   len_cnt;
    logic [LEN_W-1:0]   len_next;
    logic               pkt_done_q;
    logic [LEN_W-1:0]   pkt_len_q;
    logic               err_q;
    logic               xfer;
    logic               owner_head;

    // Pick the first requester offering a head beat, searching upward from ptr.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req_valid[idx] && req_head[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    // Forward the owner's beat downstream; head is masked once inside a packet.
    always_comb begin
        out_valid  = 1'b0;
        out_head   = 1'b0;
        out_tail   = 1'b0;
        out_data   = '0;
        req_ready  = '0;
        owner_head = req_head[owner];
        if (state != IDLE) begin
            out_valid = req_valid[owner];
            out_head  = owner_head & (state != BODY);
            out_tail  = req_tail[owner];
            out_data  = req_data[owner*DATA_W +: DATA_W];
            req_ready = grant_q & {NUM_REQ{out_ready}};
        end
        xfer     = out_valid & out_ready;
        len_next = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + LEN_W'(1);
        next_ptr = (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
    end

    // Packet-level state, ownership, length counting and error tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= '0;
            grant_q    <= '0;
            len_cnt    <= '0;
            pkt_done_q <= 1'b0;
            pkt_len_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= LOCK;
                        owner   <= pick;
                        grant_q <= NUM_REQ'(1) << pick;
                        len_cnt <= '0;
                    end
                end
                LOCK, BODY: begin
                    if (xfer) begin
                        if (state == BODY && owner_head)  err_q <= 1'b1;
                        if (state == LOCK && !owner_head) err_q <= 1'b1;
                        if (out_tail) begin
                            state      <= IDLE;
                            grant_q    <= '0;
                            ptr        <= next_ptr;
                            pkt_done_q <= 1'b1;
                            pkt_len_q  <= len_next;
                            len_cnt    <= '0;
                        end else begin
                            len_cnt <= len_next;
                            if (state == LOCK && owner_head) state <= BODY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant    = grant_q;
    assign pkt_done = pkt_done_q;
    assign pkt_len  = pkt_len_q;
    assign err      = err_q;

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
Round-robin packet arbiter that shares one framed packet channel (valid/head/tail/data) among NUM_REQ requesters. Grants are made only at packet boundaries and held from head beat through tail beat, so packets are never interleaved. The arbiter sits in front of the downstream IDLE/HEAD/DATA/TAIL framing FSM. It also reports beat length per packet and flags framing violations.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, payload width per beat
LEN_W, 8, width of the packet-length counter (saturating)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester beat valid
req_head  input  NUM_REQ  per-requester first-beat marker
req_tail  input  NUM_REQ  per-requester last-beat marker
req_data  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  beat accepted from requester i when req_valid[i] & req_ready[i]
out_valid  output  1  downstream beat valid
out_head  output  1  downstream head marker
out_tail  output  1  downstream tail marker
out_data  output  DATA_W  downstream payload
out_ready  input  1  downstream accepts beat
grant  output  NUM_REQ  one-hot current owner, all-zero when idle
pkt_done  output  1  one-cycle pulse, cycle after tail transfer
pkt_len  output  LEN_W  beat count of last completed packet, valid with pkt_done, held otherwise
err  output  1  sticky framing-error flag

Behaviour:
- Transfer = out_valid & out_ready. Requesters hold valid/head/tail/data stable until their beat is accepted.
- States: IDLE (no owner), LOCK (owner granted, waiting for head transfer), BODY (head transferred, tail not yet transferred).
- IDLE: candidate i = req_valid[i] & req_head[i]. Pick the first candidate searching from pointer ptr upward, modulo NUM_REQ. Register grant on the next edge -> LOCK. No candidate -> stay IDLE. req_ready all 0 in IDLE.
- A valid beat without head in IDLE is ignored (not accepted). It does not set err.
- LOCK/BODY: out_* = granted requester's valid/head/tail/data (combinational mux). req_ready[g] = out_ready. All other req_ready = 0.
- LOCK: on head transfer -> BODY, unless tail is also set (single-beat packet), which completes the packet.
- BODY: stays in BODY on transfers without tail. Tail transfer completes the packet.
- Packet completion on tail transfer: state -> IDLE, grant -> 0, ptr -> (g+1) mod NUM_REQ. On the next cycle pkt_done=1 and pkt_len = number of beats transferred including head and tail.
- Length counter saturates at 2^LEN_W-1.
- Minimum arbitration bubble: one cycle in IDLE between packets. Back-to-back packets from the same requester are allowed only if no other candidate precedes it from ptr.
- Framing errors:
  - head on a transfer in BODY: err set, beat forwarded with out_head forced 0.
  - in LOCK, owner's first transfer lacking head: err set, beat forwarded as-is.
  - Neither error alters state.
- err clears only on reset.
- Reset (including mid-packet): state IDLE, grant=0, ptr=0, req_ready=0, out_valid/out_head/out_tail=0, out_data=0, pkt_done=0, pkt_len=0, err=0, length counter 0. In-flight packet is abandoned. No pkt_done is produced.
- out_ready low stalls a beat with no loss. State and counters advance only on transfer.

Test Plan:
- Single requester: reset high 2 cycles, then req 1 sends head 0x11, data 0x22, tail 0x33 with out_ready=1 -> grant=4'b0010 one cycle after head is presented; three transfers; pkt_done pulse with pkt_len=3; grant returns to 0.
- Contention/fairness: reqs 0 and 2 both present head beats continuously with 2-beat packets -> grants alternate 0,2,0,2. ptr is 1 after req 0's packet and 3 after req 2's; no interleaving on out_*.
- Single-beat packet: head=tail=1, data 0xA5 on req 3 -> one transfer, pkt_len=1, state back to IDLE.
- Backpressure: out_ready low for 3 cycles mid-packet -> out_data held and req_ready low; pkt_len still counts actual beats (4 for a 4-beat packet).
- Framing error: owner asserts head on its 2nd beat in BODY -> err=1, out_head=0 on that beat, packet still completes on tail; err stays 1 until reset.
- Reset mid-packet during BODY -> next cycle grant=0, out_valid=0, err=0, no pkt_done. A new packet from req 2 is then granted first (ptr=0 search finds 2).
